// File: rtl/can_rx_msg_fifo.sv
// Receive-side CAN message buffer: ID/mask acceptance filter feeding a small
// first-word-fall-through FIFO with sticky overflow flag and saturating drop counter.
module can_rx_msg_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_valid,
  input  logic [10:0]   rx_id,
  input  logic [63:0]   rx_data,
  input  logic          filt_en,
  input  logic [10:0]   filt_id,
  input  logic [10:0]   filt_mask,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [10:0]   out_id,
  output logic [63:0]   out_data,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    drop_cnt,
  input  logic          overflow_clr
);

  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

  logic [10:0]   id_mem   [DEPTH];
  logic [63:0]   data_mem [DEPTH];

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic id_hit, accept, pop, push, drop, full;

  assign id_hit = ((rx_id ^ filt_id) & filt_mask) == 11'd0;
  assign accept = rx_valid & (~filt_en | id_hit);
  assign full   = (count_q == DepthW);
  assign pop    = out_valid & out_ready;
  // A pop frees the slot in the same edge, so a full FIFO can still take a push.
  assign push   = accept & (~full | pop);
  assign drop   = accept & ~push;

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push) wp_d = wp_q + AW'(1);
    if (pop)  rp_d = rp_q + AW'(1);

    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);

    // A drop coinciding with a clear wins: it counts as the first new drop.
    if (drop) begin
      overflow_d = 1'b1;
      if (overflow_clr)             drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Payload storage needs no reset; the output mux hides it while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wp_q]   <= rx_id;
      data_mem[wp_q] <= rx_data;
    end
  end

  always_comb begin
    out_valid = (count_q != '0);
    out_id    = out_valid ? id_mem[rp_q]   : 11'd0;
    out_data  = out_valid ? data_mem[rp_q] : 64'd0;
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_can_rx_msg_fifo.sv
// Scoreboard bench for can_rx_msg_fifo: stimulus pushes expected frames, a
// negedge monitor checks each popped head in order; status outputs checked directly.
module tb_can_rx_msg_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [10:0] rx_id;
  logic [63:0] rx_data;
  logic        filt_en;
  logic [10:0] filt_id;
  logic [10:0] filt_mask;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_id;
  logic [63:0] out_data;
  logic [2:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        overflow_clr;

  int errors = 0;
  int checks = 0;
  logic [74:0] sb[$];

  can_rx_msg_fifo #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_id(rx_id), .rx_data(rx_data),
    .filt_en(filt_en), .filt_id(filt_id), .filt_mask(filt_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_data(out_data),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens on the next rising edge whenever valid & ready now.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL head_unexpected: got id=%0h data=%0h expected no frame", out_id, out_data);
      end else begin
        logic [74:0] e;
        e = sb.pop_front();
        if ({out_id, out_data} !== e) begin
          errors++;
          $display("FAIL head: got id=%0h data=%0h expected id=%0h data=%0h",
                   out_id, out_data, e[74:64], e[63:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [10:0] id, input logic [63:0] d, input bit queued);
    rx_valid = 1'b1;
    rx_id    = id;
    rx_data  = d;
    if (queued) sb.push_back({id, d});
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic drain;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!out_valid) break;
      tick();
    end
    out_ready = 1'b0;
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; rx_valid = 0; rx_id = '0; rx_data = '0; filt_en = 0;
    filt_id = '0; filt_mask = '0; out_ready = 0; overflow_clr = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_out_id", 64'(out_id), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    #6 rst_n = 1'b1;
    tick();

    // Filter pass/reject
    filt_en = 1; filt_id = 11'h123; filt_mask = 11'h7F0;
    send(11'h12A, 64'h1111_0000_0000_0001, 1);
    send(11'h133, 64'h2222_0000_0000_0002, 0);
    send(11'h120, 64'h3333_0000_0000_0003, 1);
    chk("filt_count", 64'(count), 64'd2);
    chk("filt_head_id", 64'(out_id), 64'h12A);
    drain();

    // Filter bypass
    filt_en = 0;
    send(11'h7FF, 64'hDEADBEEF_01234567, 1);
    send(11'h000, 64'h00112233_44556677, 1);
    chk("bypass_count", 64'(count), 64'd2);
    drain();

    // Fill and overflow
    for (int i = 0; i < 6; i++) send(11'(16 + i), 64'hA000 + 64'(i), i < 4);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_overflow", 64'(overflow), 64'd1);
    chk("fill_drop_cnt", 64'(drop_cnt), 64'd2);

    // Full plus simultaneous pop and push
    out_ready = 1'b1;
    send(11'h055, 64'hBEEF_0000_0000_0055, 1);
    out_ready = 1'b0;
    chk("fullpp_count", 64'(count), 64'd4);
    chk("fullpp_drop_cnt", 64'(drop_cnt), 64'd2);
    drain();

    // Clear vs drop race
    overflow_clr = 1; tick(); overflow_clr = 0;
    chk("clr_overflow", 64'(overflow), 64'd0);
    chk("clr_drop_cnt", 64'(drop_cnt), 64'd0);
    for (int i = 0; i < 4; i++) send(11'(32 + i), 64'hC000 + 64'(i), 1);
    for (int i = 0; i < 259; i++) send(11'h3AA, 64'(i), 0);
    chk("sat_drop_cnt", 64'(drop_cnt), 64'd255);
    chk("sat_overflow", 64'(overflow), 64'd1);
    overflow_clr = 1;
    send(11'h3AB, 64'hFFFF, 0);
    overflow_clr = 0;
    chk("race_overflow", 64'(overflow), 64'd1);
    chk("race_drop_cnt", 64'(drop_cnt), 64'd1);
    overflow_clr = 1; tick(); overflow_clr = 0;
    chk("lone_clr_overflow", 64'(overflow), 64'd0);
    chk("lone_clr_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("race_count", 64'(count), 64'd4);
    drain();

    // Async reset mid-queue
    send(11'h101, 64'h1, 1);
    send(11'h102, 64'h2, 1);
    send(11'h103, 64'h3, 1);
    chk("pre_rst_count", 64'(count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_out_id", 64'(out_id), 64'd0);
    sb.delete();
    #3 rst_n = 1'b1;
    tick();
    send(11'h2BC, 64'hCAFE_F00D_1234_5678, 1);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_id", 64'(out_id), 64'h2BC);
    chk("post_rst_data", out_data, 64'hCAFE_F00D_1234_5678);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
